e203_icb_resp_stub: RTL and testbench
=====================================

E203_ICB_RESP_STUB -- requirements
Module: e203_icb_resp_stub

Interface
REQ-001 The block SHALL have parameter AW, default 32, ICB address width.
REQ-002 The block SHALL have parameter DW, default 32, ICB data width; wmask width is DW/8.
REQ-003 The block SHALL have parameter DEPTH, default 2, the maximum number of outstanding commands; legal values are powers of two from 1 to 16.
REQ-004 The block SHALL have parameter LAT, default 0, extra response delay in cycles; legal range is 0..15.
REQ-005 The block SHALL have parameter ERR_RSP, default 0, the value driven on icb_rsp_err for every response.
REQ-006 The block SHALL have parameter RDATA_VAL, default {DW{1'b0}}, the read response data.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-008 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 The block SHALL have icb_cmd_valid in 1, icb_cmd_ready out 1, icb_cmd_addr in AW, icb_cmd_read in 1, icb_cmd_wdata in DW, and icb_cmd_wmask in DW/8.
REQ-010 The block SHALL have icb_rsp_valid out 1, icb_rsp_ready in 1, icb_rsp_err out 1, and icb_rsp_rdata out DW.
REQ-011 The block SHALL have cnt_rd out 16 (accepted reads), cnt_wr out 16 (accepted writes), last_addr out AW (address of the last accepted command), and busy out 1 (outstanding entry present).

Function
REQ-012 A command SHALL be accepted in the cycle where icb_cmd_valid and icb_cmd_ready are both 1; icb_cmd_ready SHALL equal NOT full.
REQ-013 Each accepted command SHALL push one entry {read} into an in-order queue of DEPTH entries; wdata and wmask SHALL be ignored.
REQ-014 Responses SHALL leave in acceptance order; a response completes in the cycle where icb_rsp_valid and icb_rsp_ready are both 1, and that completion SHALL pop the head entry.
REQ-015 Latency into an empty queue: a command accepted in cycle T SHALL produce icb_rsp_valid first in cycle T+1+LAT.
REQ-016 Back-to-back latency: after a pop in cycle P with entries remaining, the next icb_rsp_valid SHALL first assert in cycle P+1+LAT.
REQ-017 Latency SHALL be realised with a 4-bit down-counter. The counter loads LAT when a new head becomes available, decrements while nonzero, and holds at zero. icb_rsp_valid SHALL be (queue nonempty AND counter==0), driven from registers.
REQ-018 Once asserted, icb_rsp_valid SHALL stay 1, with head response fields stable, until the handshake completes.
REQ-019 icb_rsp_rdata SHALL be RDATA_VAL for a read head and all-zeros for a write head; icb_rsp_err SHALL be ERR_RSP.
REQ-020 Simultaneous push and pop in the same cycle (not full) SHALL leave occupancy unchanged, and the pushed entry SHALL queue behind the remaining entries.
REQ-021 Full: when occupancy equals DEPTH, icb_cmd_ready SHALL be 0; a pop in that cycle SHALL NOT enable a same-cycle push.
REQ-022 Occupancy SHALL use a $clog2(DEPTH)+1 bit count; read and write pointers SHALL wrap modulo DEPTH.
REQ-023 cnt_rd and cnt_wr SHALL increment by 1 on each accepted read and write respectively, saturating at 16'hFFFF.
REQ-024 last_addr SHALL capture icb_cmd_addr on every acceptance and hold otherwise.
REQ-025 busy SHALL be 1 exactly when occupancy is nonzero.
REQ-026 icb_rsp_valid dropping without a handshake is prohibited; with icb_rsp_ready held 0, the queue SHALL fill and then stall commands indefinitely without losing entries.

Reset
REQ-027 When rst=1, the block SHALL asynchronously clear the queue, pointers, occupancy and latency counter, and set icb_rsp_valid=0, busy=0, icb_cmd_ready=1, cnt_rd=0, cnt_wr=0, last_addr=0, icb_rsp_rdata=0, and icb_rsp_err=ERR_RSP.
REQ-028 Reset asserted mid-transaction SHALL discard all outstanding entries; no response for them SHALL appear after deassertion.
REQ-029 The first acceptance SHALL be possible in the first rising edge after rst deasserts.

Verification
REQ-030 LAT=0, DEPTH=2: read to 0x1000 accepted at cycle 5, rsp_ready=1 -> rsp_valid=1 at cycle 6, rdata=RDATA_VAL, err=ERR_RSP, cnt_rd=1, last_addr=0x1000.
REQ-031 LAT=3: write accepted at cycle 10 -> rsp_valid=1 first at cycle 14, rdata=0, cnt_wr=1.
REQ-032 DEPTH=2, rsp_ready=0, continuous cmd_valid -> two accepts, then cmd_ready=0, busy=1; rsp_ready=1 -> responses in order read then write, cmd_ready returns 1 the cycle after the first pop.
REQ-033 Interleaved R,W,R with rsp_ready random -> rdata sequence RDATA_VAL,0,RDATA_VAL, no drops or duplicates, and valid held stable while stalled.
REQ-034 Assert rst with 2 entries outstanding -> in the same cycle rsp_valid=0, busy=0, counters=0; no responses after release.
REQ-035 Preload cnt_rd near saturation via 65537 reads -> cnt_rd=16'hFFFF and holds.

Source files
------------

// File: rtl/e203_icb_resp_stub.sv
// ICB response stub: accepts commands into an in-order queue that holds only
// the read/write flag. It answers each command with a fixed response after a
// programmable extra delay. It also keeps simple traffic statistics.
module e203_icb_resp_stub #(
  parameter int              AW        = 32,
  parameter int              DW        = 32,
  parameter int              DEPTH     = 2,
  parameter int              LAT       = 0,
  parameter bit              ERR_RSP   = 1'b0,
  parameter logic [DW-1:0]   RDATA_VAL = {DW{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icb_cmd_valid,
  output logic              icb_cmd_ready,
  input  logic [AW-1:0]     icb_cmd_addr,
  input  logic              icb_cmd_read,
  input  logic [DW-1:0]     icb_cmd_wdata,
  input  logic [DW/8-1:0]   icb_cmd_wmask,
  output logic              icb_rsp_valid,
  input  logic              icb_rsp_ready,
  output logic              icb_rsp_err,
  output logic [DW-1:0]     icb_rsp_rdata,
  output logic [15:0]       cnt_rd,
  output logic [15:0]       cnt_wr,
  output logic [AW-1:0]     last_addr,
  output logic              busy
);

  // A single-entry queue still needs a one-bit pointer. That pointer never
  // leaves zero because the wrap compare below always selects zero.
  localparam int             PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int             CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
  localparam logic [3:0]     LAT_LD   = 4'(LAT);

  logic [DEPTH-1:0] q_read;
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [PW-1:0]    rptr_nxt;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic [3:0]       lat_cnt;
  logic [3:0]       lat_nxt;
  logic             push;
  logic             pop;
  logic             new_head;
  logic             head_read_nxt;

  // Write data and mask are accepted but carry no meaning for a stub.
  logic unused_wdata;
  assign unused_wdata = ^{icb_cmd_wdata, icb_cmd_wmask};

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    else                     return p + 1'b1;
  endfunction

  assign icb_cmd_ready = (count != FULL_CNT);
  assign busy          = (count != '0);
  assign icb_rsp_err   = ERR_RSP;

  // Next-state view of the queue: handshakes, new head detection, delay counter.
  always_comb begin
    push     = icb_cmd_valid && icb_cmd_ready;
    pop      = icb_rsp_valid && icb_rsp_ready;
    rptr_nxt = pop ? ptr_inc(rptr) : rptr;
    count_nxt = count + CW'(push) - CW'(pop);
    // A head is "new" when a push lands in an empty queue or when a pop
    // exposes the next entry. Either case restarts the delay.
    new_head = (push && (count == '0)) || (pop && (count_nxt != '0));
    if (new_head)              lat_nxt = LAT_LD;
    else if (lat_cnt != 4'd0)  lat_nxt = lat_cnt - 4'd1;
    else                       lat_nxt = 4'd0;
    // The slot being written becomes the head when the queue is otherwise empty.
    if (push && (wptr == rptr_nxt)) head_read_nxt = icb_cmd_read;
    else                            head_read_nxt = q_read[rptr_nxt];
  end

  // Queue storage, pointers, delay counter and registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_read        <= '0;
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      lat_cnt       <= 4'd0;
      icb_rsp_valid <= 1'b0;
      icb_rsp_rdata <= '0;
    end else begin
      if (push) begin
        q_read[wptr] <= icb_cmd_read;
        wptr         <= ptr_inc(wptr);
      end
      rptr          <= rptr_nxt;
      count         <= count_nxt;
      lat_cnt       <= lat_nxt;
      icb_rsp_valid <= (count_nxt != '0) && (lat_nxt == 4'd0);
      icb_rsp_rdata <= ((count_nxt != '0) && head_read_nxt) ? RDATA_VAL : '0;
    end
  end

  // Saturating accept counters and last accepted address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_rd    <= 16'd0;
      cnt_wr    <= 16'd0;
      last_addr <= '0;
    end else if (push) begin
      last_addr <= icb_cmd_addr;
      if (icb_cmd_read) begin
        if (cnt_rd != 16'hFFFF) cnt_rd <= cnt_rd + 16'd1;
      end else begin
        if (cnt_wr != 16'hFFFF) cnt_wr <= cnt_wr + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_e203_icb_resp_stub.sv
// Bench for e203_icb_resp_stub: two instances with different depth, latency
// and response constants, checked every cycle against a queue-based model.
module tb_e203_icb_resp_stub;

  localparam int          DEPTH0 = 2;
  localparam int          LAT0   = 0;
  localparam bit          ERR0   = 1'b0;
  localparam logic [31:0] RV0    = 32'hA5A5_0001;
  localparam int          DEPTH1 = 4;
  localparam int          LAT1   = 3;
  localparam bit          ERR1   = 1'b1;
  localparam logic [31:0] RV1    = 32'h5EED_C0DE;

  typedef struct {
    bit rd;
    int acc;
  } ent_t;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  logic        clk = 1'b0;
  logic [1:0]  rst;
  logic [1:0]  cmd_valid;
  logic [1:0]  cmd_ready;
  logic [1:0]  cmd_read;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [1:0]  rsp_err;
  logic [1:0]  busy;
  logic [31:0] cmd_addr  [2];
  logic [31:0] cmd_wdata [2];
  logic [3:0]  cmd_wmask [2];
  logic [31:0] rsp_rdata [2];
  logic [15:0] cnt_rd    [2];
  logic [15:0] cnt_wr    [2];
  logic [31:0] last_addr [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  e203_icb_resp_stub #(.AW(32), .DW(32), .DEPTH(DEPTH0), .LAT(LAT0),
                       .ERR_RSP(ERR0), .RDATA_VAL(RV0)) u0 (
    .clk(clk), .rst(rst[0]),
    .icb_cmd_valid(cmd_valid[0]), .icb_cmd_ready(cmd_ready[0]),
    .icb_cmd_addr(cmd_addr[0]), .icb_cmd_read(cmd_read[0]),
    .icb_cmd_wdata(cmd_wdata[0]), .icb_cmd_wmask(cmd_wmask[0]),
    .icb_rsp_valid(rsp_valid[0]), .icb_rsp_ready(rsp_ready[0]),
    .icb_rsp_err(rsp_err[0]), .icb_rsp_rdata(rsp_rdata[0]),
    .cnt_rd(cnt_rd[0]), .cnt_wr(cnt_wr[0]), .last_addr(last_addr[0]),
    .busy(busy[0]));

  e203_icb_resp_stub #(.AW(32), .DW(32), .DEPTH(DEPTH1), .LAT(LAT1),
                       .ERR_RSP(ERR1), .RDATA_VAL(RV1)) u1 (
    .clk(clk), .rst(rst[1]),
    .icb_cmd_valid(cmd_valid[1]), .icb_cmd_ready(cmd_ready[1]),
    .icb_cmd_addr(cmd_addr[1]), .icb_cmd_read(cmd_read[1]),
    .icb_cmd_wdata(cmd_wdata[1]), .icb_cmd_wmask(cmd_wmask[1]),
    .icb_rsp_valid(rsp_valid[1]), .icb_rsp_ready(rsp_ready[1]),
    .icb_rsp_err(rsp_err[1]), .icb_rsp_rdata(rsp_rdata[1]),
    .cnt_rd(cnt_rd[1]), .cnt_wr(cnt_wr[1]), .last_addr(last_addr[1]),
    .busy(busy[1]));

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  // Reference model: an entry becomes the head at max(accept, previous pop).
  // It is then due 1+LAT cycles later and stays due until it is popped.
  for (genvar g = 0; g < 2; g++) begin : g_mdl
    localparam int          D  = (g == 0) ? DEPTH0 : DEPTH1;
    localparam int          L  = (g == 0) ? LAT0 : LAT1;
    localparam bit          E  = (g == 0) ? ERR0 : ERR1;
    localparam logic [31:0] RV = (g == 0) ? RV0 : RV1;

    ent_t        q[$];
    int          last_pop = -100;
    int unsigned n_rd     = 0;
    int unsigned n_wr     = 0;
    logic [31:0] l_addr   = '0;

    function automatic bit exp_valid();
      int start;
      if (q.size() == 0) return 1'b0;
      start = (q[0].acc > last_pop) ? q[0].acc : last_pop;
      return cyc >= start + 1 + L;
    endfunction

    initial forever begin
      @(posedge clk or posedge rst[g]);
      if (rst[g]) begin
        q.delete();
        last_pop = -100;
        n_rd     = 0;
        n_wr     = 0;
        l_addr   = '0;
      end else begin
        bit pop;
        bit acc;
        pop = exp_valid() && rsp_ready[g];
        acc = cmd_valid[g] && (q.size() < D);
        if (pop) begin
          void'(q.pop_front());
          last_pop = cyc;
        end
        if (acc) begin
          q.push_back(ent_t'{cmd_read[g], cyc});
          l_addr = cmd_addr[g];
          if (cmd_read[g]) begin
            if (n_rd < 65535) n_rd++;
          end else begin
            if (n_wr < 65535) n_wr++;
          end
        end
      end
    end

    initial forever begin
      @(negedge clk);
      chk($sformatf("u%0d rsp_valid", g), 32'(rsp_valid[g]), 32'(exp_valid()));
      chk($sformatf("u%0d cmd_ready", g), 32'(cmd_ready[g]), 32'(q.size() < D));
      chk($sformatf("u%0d busy", g),      32'(busy[g]),      32'(q.size() != 0));
      chk($sformatf("u%0d rsp_err", g),   32'(rsp_err[g]),   32'(E));
      chk($sformatf("u%0d cnt_rd", g),    32'(cnt_rd[g]),    n_rd);
      chk($sformatf("u%0d cnt_wr", g),    32'(cnt_wr[g]),    n_wr);
      chk($sformatf("u%0d last_addr", g), last_addr[g],      l_addr);
      if (exp_valid())
        chk($sformatf("u%0d rsp_rdata", g), rsp_rdata[g], q[0].rd ? RV : 32'h0);
    end
  end

  task automatic drive(input int i, input bit v, input bit rd, input logic [31:0] a, input bit rr);
    cmd_valid[i] = v;
    cmd_read[i]  = rd;
    cmd_addr[i]  = a;
    rsp_ready[i] = rr;
    cmd_wdata[i] = $urandom;
    cmd_wmask[i] = 4'($urandom);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 2'b11;
    cmd_valid = 2'b00;
    cmd_read  = 2'b00;
    rsp_ready = 2'b00;
    for (int i = 0; i < 2; i++) begin
      cmd_addr[i]  = '0;
      cmd_wdata[i] = '0;
      cmd_wmask[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst u0 rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rst u0 cmd_ready", 32'(cmd_ready[0]), 32'd1);
    chk("rst u0 busy",      32'(busy[0]),      32'd0);
    chk("rst u0 cnt_rd",    32'(cnt_rd[0]),    32'd0);
    chk("rst u0 last_addr", last_addr[0],      32'd0);
    chk("rst u0 rsp_rdata", rsp_rdata[0],      32'd0);
    chk("rst u0 rsp_err",   32'(rsp_err[0]),   32'd0);
    chk("rst u1 rsp_err",   32'(rsp_err[1]),   32'd1);
    chk("rst u1 rsp_rdata", rsp_rdata[1],      32'd0);

    // Release reset with a command already pending: the very next edge accepts it.
    @(posedge clk); #1;
    rst = 2'b00;
    drive(0, 1'b1, 1'b1, 32'h1000, 1'b1);
    drive(1, 1'b1, 1'b0, 32'h2000, 1'b1);
    @(negedge clk);
    chk("u0 valid in accept cycle", 32'(rsp_valid[0]), 32'd0);
    step();
    cmd_valid = 2'b00;
    @(negedge clk);
    chk("u0 first rsp valid", 32'(rsp_valid[0]), 32'd1);
    chk("u0 first rsp rdata", rsp_rdata[0],      RV0);
    chk("u0 first rsp err",   32'(rsp_err[0]),   32'd0);
    chk("u0 first cnt_rd",    32'(cnt_rd[0]),    32'd1);
    chk("u0 first last_addr", last_addr[0],      32'h1000);
    chk("u1 valid at T+1",    32'(rsp_valid[1]), 32'd0);
    chk("u1 first cnt_wr",    32'(cnt_wr[1]),    32'd1);
    for (int k = 2; k <= 4; k++) begin
      step();
      @(negedge clk);
      chk($sformatf("u1 valid at T+%0d", k), 32'(rsp_valid[1]), 32'(k == 4));
    end
    chk("u1 write rdata", rsp_rdata[1], 32'd0);
    repeat (4) step();

    // Fill u0 with responses stalled, then release and watch ordering.
    drive(0, 1'b1, 1'b1, 32'h10, 1'b0);
    step();
    drive(0, 1'b1, 1'b0, 32'h14, 1'b0);
    step();
    drive(0, 1'b1, 1'b1, 32'h18, 1'b0);
    @(negedge clk);
    chk("u0 full cmd_ready", 32'(cmd_ready[0]), 32'd0);
    chk("u0 full busy",      32'(busy[0]),      32'd1);
    repeat (3) step();
    @(negedge clk);
    chk("u0 stalled valid", 32'(rsp_valid[0]), 32'd1);
    chk("u0 stalled rdata", rsp_rdata[0],      RV0);
    step();
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    chk("u0 pop cycle cmd_ready", 32'(cmd_ready[0]), 32'd0);
    chk("u0 rsp1 rdata",          rsp_rdata[0],      RV0);
    step();
    @(negedge clk);
    chk("u0 after pop cmd_ready", 32'(cmd_ready[0]), 32'd1);
    chk("u0 rsp2 valid",          32'(rsp_valid[0]), 32'd1);
    chk("u0 rsp2 rdata",          rsp_rdata[0],      32'd0);
    step();
    cmd_valid[0] = 1'b0;
    @(negedge clk);
    chk("u0 rsp3 rdata",  rsp_rdata[0],    RV0);
    chk("u0 cnt_rd 3",    32'(cnt_rd[0]),  32'd3);
    chk("u0 cnt_wr 1",    32'(cnt_wr[0]),  32'd1);
    chk("u0 last 0x18",   last_addr[0],    32'h18);
    for (int i = 0; i < 2; i++) drive(i, 1'b0, 1'b0, 32'h0, 1'b1);
    repeat (6) step();

    // Reset with two entries outstanding in each instance.
    drive(0, 1'b1, 1'b1, 32'h20, 1'b0);
    drive(1, 1'b1, 1'b1, 32'h30, 1'b0);
    step();
    drive(0, 1'b1, 1'b0, 32'h24, 1'b0);
    drive(1, 1'b1, 1'b0, 32'h34, 1'b0);
    step();
    cmd_valid = 2'b00;
    @(negedge clk);
    chk("u0 pre-reset busy", 32'(busy[0]), 32'd1);
    chk("u1 pre-reset busy", 32'(busy[1]), 32'd1);
    @(posedge clk); #1;
    rst = 2'b11;
    #1;
    chk("u0 async rst valid",  32'(rsp_valid[0]), 32'd0);
    chk("u0 async rst busy",   32'(busy[0]),      32'd0);
    chk("u0 async rst cnt_rd", 32'(cnt_rd[0]),    32'd0);
    chk("u0 async rst cnt_wr", 32'(cnt_wr[0]),    32'd0);
    chk("u0 async rst ready",  32'(cmd_ready[0]), 32'd1);
    chk("u1 async rst busy",   32'(busy[1]),      32'd0);
    chk("u1 async rst cnt_rd", 32'(cnt_rd[1]),    32'd0);
    step();
    rst       = 2'b00;
    rsp_ready = 2'b11;
    repeat (6) step();
    @(negedge clk);
    chk("u0 no rsp after rst", 32'(rsp_valid[0]), 32'd0);
    chk("u1 no rsp after rst", 32'(rsp_valid[1]), 32'd0);

    // Random traffic with periodic response stalls that fill the queues.
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 2; i++)
        drive(i, ($urandom_range(3) != 0), 1'($urandom), $urandom,
              ((n % 100) < 15) ? 1'b0 : 1'($urandom));
      step();
    end

    // Saturate u0's read counter with a long back-to-back read burst.
    for (int i = 0; i < 2; i++) drive(i, 1'b0, 1'b0, 32'h0, 1'b1);
    drive(0, 1'b1, 1'b1, 32'hABC0, 1'b1);
    repeat (65600) step();
    @(negedge clk);
    chk("u0 cnt_rd saturated", 32'(cnt_rd[0]), 32'h0000_FFFF);
    repeat (10) step();
    @(negedge clk);
    chk("u0 cnt_rd holds", 32'(cnt_rd[0]), 32'h0000_FFFF);
    cmd_valid = 2'b00;
    repeat (4) step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
